// File: rtl/dispatch_pkg.sv
// Shared dispatch types: instruction classes, tag layout and per-channel packet formats.
// Tag = {valid, unit, index}; an all-zero tag means the operand value is already present.
package dispatch_pkg;

    localparam int XLEN    = 32;
    localparam int CLS_W   = 4;
    localparam int OP_W    = 6;
    localparam int IDX_W   = 4;
    localparam int TAG_W   = IDX_W + 2;

    localparam logic [OP_W-1:0]  NOP      = '0;
    localparam logic [TAG_W-1:0] TAG_FREE = '0;
    localparam logic             UNIT_ALU = 1'b0;
    localparam logic             UNIT_LS  = 1'b1;

    typedef enum logic [CLS_W-1:0] {
        CLS_NONE  = 4'd0,
        CLS_LUI   = 4'd1,
        CLS_AUIPC = 4'd2,
        CLS_JAL   = 4'd3,
        CLS_JALR  = 4'd4,
        CLS_RI    = 4'd5,
        CLS_RR    = 4'd6,
        CLS_B     = 4'd7,
        CLS_LD    = 4'd8,
        CLS_ST    = 4'd9,
        CLS_SYS   = 4'd10
    } cls_e;

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic [OP_W-1:0] op;
        tag_t            dest;
        tag_t            tag1;
        logic [XLEN-1:0] data1;
        tag_t            tag2;
        logic [XLEN-1:0] data2;
        logic [XLEN-1:0] addr;
    } alu_pkt_t;

    typedef struct packed {
        logic [OP_W-1:0] op;
        tag_t            tag1;
        logic [XLEN-1:0] data1;
        tag_t            tag2;
        logic [XLEN-1:0] data2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] addr;
    } br_pkt_t;

    typedef struct packed {
        logic [OP_W-1:0] op;
        tag_t            dest;
        tag_t            tag1;
        logic [XLEN-1:0] data1;
        tag_t            tag2;
        logic [XLEN-1:0] data2;
        logic [XLEN-1:0] imm;
    } ls_pkt_t;

    function automatic tag_t make_tag(input logic unit, input logic [IDX_W-1:0] idx);
        return {1'b1, unit, idx};
    endfunction

endpackage

// File: rtl/dispatch_stage_if.sv
// Decoder, regfile, reservation-station and rename signals seen by the dispatch stage.
// master = surrounding pipeline, slave = dispatch_stage.
interface dispatch_stage_if #(
    parameter int DATA_W    = 32,
    parameter int NAME_W    = 5,
    parameter int ALU_DEPTH = 16,
    parameter int LS_DEPTH  = 16
) ();
    import dispatch_pkg::*;

    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [CLS_W-1:0]     in_class;
    logic [OP_W-1:0]      in_op;
    logic [DATA_W-1:0]    in_addr;
    logic [NAME_W-1:0]    in_rd;
    logic [DATA_W-1:0]    in_imm;
    logic [TAG_W-1:0]     src1_tag;
    logic [TAG_W-1:0]     src2_tag;
    logic [DATA_W-1:0]    src1_data;
    logic [DATA_W-1:0]    src2_data;
    logic [ALU_DEPTH-1:0] alu_free;
    logic [LS_DEPTH-1:0]  ls_free;
    logic                 ren_en;
    logic [NAME_W-1:0]    ren_name;
    logic [TAG_W-1:0]     ren_tag;
    logic                 alu_valid;
    logic                 alu_ready;
    alu_pkt_t             alu_pkt;
    logic                 br_valid;
    logic                 br_ready;
    br_pkt_t              br_pkt;
    logic                 ls_valid;
    logic                 ls_ready;
    ls_pkt_t              ls_pkt;

    modport master (
        output flush, in_valid, in_class, in_op, in_addr, in_rd, in_imm,
               src1_tag, src2_tag, src1_data, src2_data, alu_free, ls_free,
               alu_ready, br_ready, ls_ready,
        input  in_ready, ren_en, ren_name, ren_tag,
               alu_valid, alu_pkt, br_valid, br_pkt, ls_valid, ls_pkt
    );

    modport slave (
        input  flush, in_valid, in_class, in_op, in_addr, in_rd, in_imm,
               src1_tag, src2_tag, src1_data, src2_data, alu_free, ls_free,
               alu_ready, br_ready, ls_ready,
        output in_ready, ren_en, ren_name, ren_tag,
               alu_valid, alu_pkt, br_valid, br_pkt, ls_valid, ls_pkt
    );

endinterface

// File: rtl/dispatch_stage_free_tag_picker.sv
// Lowest-set-bit picker over (vec & ~mask); purely combinational, no handshake.
module free_tag_picker #(
    parameter  int W  = 16,
    localparam int IW = $clog2(W)
) (
    input  logic [W-1:0]  vec,
    input  logic [W-1:0]  mask,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [W-1:0] avail;
    assign avail = vec & ~mask;

    // Scan downward so the last hit written is the lowest index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (avail[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/dispatch_stage.sv
// Routes decoded instructions to ALU/BR/LS channels with tag allocation and rename; 1-cycle latency.
// Accepts only when the target slot is empty or draining and a free entry exists; payload holds while stalled.
module dispatch_stage
    import dispatch_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NAME_W    = 5,
    parameter int ALU_DEPTH = 16,
    parameter int LS_DEPTH  = 16
) (
    input logic       clk,
    input logic       rst,
    dispatch_stage_if.slave bus
);

    localparam int AIW = $clog2(ALU_DEPTH);
    localparam int LIW = $clog2(LS_DEPTH);

    logic [ALU_DEPTH-1:0] alu_infl;
    logic [LS_DEPTH-1:0]  ls_infl;
    logic                 alu_found;
    logic                 ls_found;
    logic [AIW-1:0]       alu_idx;
    logic [LIW-1:0]       ls_idx;

    free_tag_picker #(.W(ALU_DEPTH)) u_alu_pick (
        .vec(bus.alu_free), .mask(alu_infl), .found(alu_found), .idx(alu_idx)
    );

    free_tag_picker #(.W(LS_DEPTH)) u_ls_pick (
        .vec(bus.ls_free), .mask(ls_infl), .found(ls_found), .idx(ls_idx)
    );

    cls_e cls;
    logic is_alu, is_br, is_ld, is_st, is_ls, use_src2;
    assign cls = cls_e'(bus.in_class);

    always_comb begin
        is_alu   = 1'b0;
        is_br    = 1'b0;
        is_ld    = 1'b0;
        is_st    = 1'b0;
        use_src2 = 1'b0;
        case (cls)
            CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_RI: is_alu = 1'b1;
            CLS_RR: begin is_alu = 1'b1; use_src2 = 1'b1; end
            CLS_B:  begin is_br  = 1'b1; use_src2 = 1'b1; end
            CLS_LD: is_ld = 1'b1;
            CLS_ST: begin is_st  = 1'b1; use_src2 = 1'b1; end
            default: ;
        endcase
    end
    assign is_ls = is_ld | is_st;

    logic alu_valid_q, br_valid_q, ls_valid_q;
    logic alu_slot, br_slot, ls_slot, in_ready_c, xfer;

    assign alu_slot = !alu_valid_q || bus.alu_ready;
    assign br_slot  = !br_valid_q  || bus.br_ready;
    assign ls_slot  = !ls_valid_q  || bus.ls_ready;

    // Unroutable classes are still consumed so the decoder never wedges on them.
    always_comb begin
        if (bus.flush)   in_ready_c = 1'b0;
        else if (is_alu) in_ready_c = alu_slot && alu_found;
        else if (is_br)  in_ready_c = br_slot;
        else if (is_ls)  in_ready_c = ls_slot && ls_found;
        else             in_ready_c = 1'b1;
    end
    assign xfer = bus.in_valid && in_ready_c;

    // Depths above 2**IDX_W do not fit the tag index field.
    tag_t                 alu_dtag, ls_dtag, op2_tag;
    logic [DATA_W-1:0]    op2_data;
    logic [ALU_DEPTH-1:0] alu_set;
    logic [LS_DEPTH-1:0]  ls_set;

    assign alu_dtag = make_tag(UNIT_ALU, IDX_W'(alu_idx));
    assign ls_dtag  = make_tag(UNIT_LS, IDX_W'(ls_idx));
    assign op2_tag  = use_src2 ? bus.src2_tag  : TAG_FREE;
    assign op2_data = use_src2 ? bus.src2_data : bus.in_imm;
    assign alu_set  = (xfer && is_alu) ? (ALU_DEPTH'(1) << alu_idx) : '0;
    assign ls_set   = (xfer && is_ls)  ? (LS_DEPTH'(1)  << ls_idx)  : '0;

    alu_pkt_t          alu_pkt_q;
    br_pkt_t           br_pkt_q;
    ls_pkt_t           ls_pkt_q;
    logic              ren_en_q;
    logic [NAME_W-1:0] ren_name_q;
    tag_t              ren_tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_valid_q <= 1'b0;
            br_valid_q  <= 1'b0;
            ls_valid_q  <= 1'b0;
            alu_pkt_q   <= '0;
            br_pkt_q    <= '0;
            ls_pkt_q    <= '0;
            ren_en_q    <= 1'b0;
            ren_name_q  <= '0;
            ren_tag_q   <= TAG_FREE;
            alu_infl    <= '0;
            ls_infl     <= '0;
        end else if (bus.flush) begin
            alu_valid_q <= 1'b0;
            br_valid_q  <= 1'b0;
            ls_valid_q  <= 1'b0;
            ren_en_q    <= 1'b0;
            alu_infl    <= '0;
            ls_infl     <= '0;
        end else begin
            if (xfer && is_alu) begin
                alu_valid_q <= 1'b1;
                alu_pkt_q   <= '{op: bus.in_op, dest: alu_dtag,
                                 tag1: bus.src1_tag, data1: bus.src1_data,
                                 tag2: op2_tag, data2: op2_data, addr: bus.in_addr};
            end else if (bus.alu_ready) begin
                alu_valid_q <= 1'b0;
            end

            if (xfer && is_br) begin
                br_valid_q <= 1'b1;
                br_pkt_q   <= '{op: bus.in_op, tag1: bus.src1_tag, data1: bus.src1_data,
                                tag2: op2_tag, data2: op2_data,
                                imm: bus.in_imm, addr: bus.in_addr};
            end else if (bus.br_ready) begin
                br_valid_q <= 1'b0;
            end

            if (xfer && is_ls) begin
                ls_valid_q <= 1'b1;
                ls_pkt_q   <= '{op: bus.in_op, dest: ls_dtag,
                                tag1: bus.src1_tag, data1: bus.src1_data,
                                tag2: op2_tag, data2: op2_data, imm: bus.in_imm};
            end else if (bus.ls_ready) begin
                ls_valid_q <= 1'b0;
            end

            // Stores and rd=0 writers still allocate, but nothing is renamed.
            ren_en_q <= xfer && (is_alu || is_ld) && (bus.in_rd != '0);
            if (xfer && (is_alu || is_ld)) begin
                ren_name_q <= bus.in_rd;
                ren_tag_q  <= is_ld ? ls_dtag : alu_dtag;
            end

            // An entry stays in flight until the station reports it occupied; a new claim wins.
            alu_infl <= (alu_infl & bus.alu_free) | alu_set;
            ls_infl  <= (ls_infl  & bus.ls_free)  | ls_set;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.alu_valid = alu_valid_q;
    assign bus.alu_pkt   = alu_pkt_q;
    assign bus.br_valid  = br_valid_q;
    assign bus.br_pkt    = br_pkt_q;
    assign bus.ls_valid  = ls_valid_q;
    assign bus.ls_pkt    = ls_pkt_q;
    assign bus.ren_en    = ren_en_q;
    assign bus.ren_name  = ren_name_q;
    assign bus.ren_tag   = ren_tag_q;

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed bench for dispatch_stage: routing, tag allocation, stalls, flush and reset.
module tb_dispatch_stage;
    import dispatch_pkg::*;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    dispatch_stage_if #(.DATA_W(32), .NAME_W(5), .ALU_DEPTH(16), .LS_DEPTH(16)) bus ();

    dispatch_stage #(.DATA_W(32), .NAME_W(5), .ALU_DEPTH(16), .LS_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] c, input logic [5:0] op, input logic [4:0] rd,
                        input logic [31:0] imm, input logic [31:0] addr);
        bus.in_valid = 1'b1;
        bus.in_class = c;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_imm   = imm;
        bus.in_addr  = addr;
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;     bus.in_valid = 1'b0;  bus.in_class = '0;
        bus.in_op = '0;       bus.in_addr = '0;     bus.in_rd = '0;      bus.in_imm = '0;
        bus.src1_tag = '0;    bus.src2_tag = '0;    bus.src1_data = 32'h11;
        bus.src2_data = 32'h22;
        bus.alu_free = '0;    bus.ls_free = '0;
        bus.alu_ready = 1'b1; bus.br_ready = 1'b1;  bus.ls_ready = 1'b1;
        #12;
        check("rst_alu_valid", 64'(bus.alu_valid), 64'd0);
        check("rst_br_valid",  64'(bus.br_valid), 64'd0);
        check("rst_ls_valid",  64'(bus.ls_valid), 64'd0);
        check("rst_ren_en",    64'(bus.ren_en), 64'd0);
        check("rst_alu_op",    64'(bus.alu_pkt.op), 64'd0);
        rst = 1'b0;

        // RR with rd=3 lands in ALU entry 1 and renames r3
        bus.alu_free = 16'h0006;
        send(CLS_RR, 6'd7, 5'd3, 32'h0, 32'h100);
        #1 check("rr_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("rr_alu_valid", 64'(bus.alu_valid), 64'd1);
        check("rr_dest",      64'(bus.alu_pkt.dest), 64'h21);
        check("rr_op",        64'(bus.alu_pkt.op), 64'd7);
        check("rr_data2",     64'(bus.alu_pkt.data2), 64'h22);
        check("rr_addr",      64'(bus.alu_pkt.addr), 64'h100);
        check("rr_ren_en",    64'(bus.ren_en), 64'd1);
        check("rr_ren_name",  64'(bus.ren_name), 64'd3);
        check("rr_ren_tag",   64'(bus.ren_tag), 64'h21);

        // unknown class is consumed with no output; free=0 retires the in-flight entry
        send(CLS_SYS, 6'd1, 5'd1, 32'h0, 32'h0);
        bus.alu_free = 16'h0000;
        #1 check("sys_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("sys_alu_valid", 64'(bus.alu_valid), 64'd0);
        check("sys_br_valid",  64'(bus.br_valid), 64'd0);
        check("sys_ls_valid",  64'(bus.ls_valid), 64'd0);
        check("sys_ren_en",    64'(bus.ren_en), 64'd0);

        // back-to-back RI: indices 1 then 2, imm replaces src2
        bus.alu_free = 16'h0006;
        bus.src2_tag = 6'h2A;
        send(CLS_RI, 6'd3, 5'd5, 32'h55, 32'h104);
        step();
        check("ri0_dest",  64'(bus.alu_pkt.dest), 64'h21);
        check("ri0_tag2",  64'(bus.alu_pkt.tag2), 64'h0);
        check("ri0_data2", 64'(bus.alu_pkt.data2), 64'h55);
        step();
        check("ri1_dest",  64'(bus.alu_pkt.dest), 64'h22);
        check("ri1_valid", 64'(bus.alu_valid), 64'd1);
        #1 check("ri_exhausted_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b0;
        bus.alu_free = 16'h0000;
        step();

        // LD stalls with no free LS entry, then takes entry 15
        send(CLS_LD, 6'd4, 5'd4, 32'h8, 32'h0);
        #1 check("ld_noentry_ready", 64'(bus.in_ready), 64'd0);
        step();
        check("ld_noentry_valid", 64'(bus.ls_valid), 64'd0);
        bus.ls_free = 16'h8000;
        #1 check("ld_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("ld_valid",    64'(bus.ls_valid), 64'd1);
        check("ld_dest",     64'(bus.ls_pkt.dest), 64'h3F);
        check("ld_tag2",     64'(bus.ls_pkt.tag2), 64'h0);
        check("ld_data2",    64'(bus.ls_pkt.data2), 64'h8);
        check("ld_ren_en",   64'(bus.ren_en), 64'd1);
        check("ld_ren_name", 64'(bus.ren_name), 64'd4);
        check("ld_ren_tag",  64'(bus.ren_tag), 64'h3F);

        // B held by br_ready=0: payload stable, second B stalls
        bus.ls_free  = 16'h0000;
        bus.br_ready = 1'b0;
        bus.src2_tag = 6'h23;
        send(CLS_B, 6'd9, 5'd0, 32'h40, 32'h200);
        step();
        check("b_valid", 64'(bus.br_valid), 64'd1);
        check("b_ren_en", 64'(bus.ren_en), 64'd0);
        check("b_tag2",  64'(bus.br_pkt.tag2), 64'h23);
        send(CLS_B, 6'd10, 5'd0, 32'h44, 32'h300);
        #1 check("b2_stall_ready", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("b_hold_valid", 64'(bus.br_valid), 64'd1);
            check("b_hold_addr",  64'(bus.br_pkt.addr), 64'h200);
            check("b_hold_imm",   64'(bus.br_pkt.imm), 64'h40);
        end
        bus.br_ready = 1'b1;
        #1 check("b2_drain_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("b2_addr", 64'(bus.br_pkt.addr), 64'h300);
        bus.in_valid = 1'b0;
        step();
        check("b_drained", 64'(bus.br_valid), 64'd0);

        // ST keeps its src2 tag, allocates entry 4, no rename
        bus.ls_free   = 16'h0010;
        bus.src2_tag  = 6'h25;
        bus.src2_data = 32'h77;
        send(CLS_ST, 6'd5, 5'd7, 32'h10, 32'h0);
        step();
        check("st_valid",  64'(bus.ls_valid), 64'd1);
        check("st_tag2",   64'(bus.ls_pkt.tag2), 64'h25);
        check("st_data2",  64'(bus.ls_pkt.data2), 64'h77);
        check("st_dest",   64'(bus.ls_pkt.dest), 64'h34);
        check("st_ren_en", 64'(bus.ren_en), 64'd0);
        bus.in_valid = 1'b0;
        step();

        // fill all three channels, then flush
        bus.alu_ready = 1'b0; bus.br_ready = 1'b0; bus.ls_ready = 1'b0;
        bus.alu_free  = 16'h0006;
        bus.ls_free   = 16'h0002;
        send(CLS_RR, 6'd1, 5'd2, 32'h0, 32'h0);
        step();
        send(CLS_B, 6'd2, 5'd0, 32'h0, 32'h0);
        step();
        send(CLS_LD, 6'd3, 5'd6, 32'h0, 32'h0);
        step();
        check("full_alu", 64'(bus.alu_valid), 64'd1);
        check("full_br",  64'(bus.br_valid), 64'd1);
        check("full_ls",  64'(bus.ls_valid), 64'd1);
        bus.flush = 1'b1;
        send(CLS_RR, 6'd1, 5'd2, 32'h0, 32'h0);
        #1 check("flush_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        check("flush_alu",    64'(bus.alu_valid), 64'd0);
        check("flush_br",     64'(bus.br_valid), 64'd0);
        check("flush_ls",     64'(bus.ls_valid), 64'd0);
        check("flush_ren_en", 64'(bus.ren_en), 64'd0);
        bus.flush = 1'b0;
        step();
        check("post_flush_dest", 64'(bus.alu_pkt.dest), 64'h21);
        check("post_flush_valid", 64'(bus.alu_valid), 64'd1);

        // asynchronous reset in the middle of a stall
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_alu_valid", 64'(bus.alu_valid), 64'd0);
        check("rst_mid_alu_dest",  64'(bus.alu_pkt.dest), 64'd0);
        check("rst_mid_alu_op",    64'(bus.alu_pkt.op), 64'd0);
        check("rst_mid_ren_en",    64'(bus.ren_en), 64'd0);
        check("rst_mid_ren_tag",   64'(bus.ren_tag), 64'd0);
        step();
        rst = 1'b0;
        send(CLS_RR, 6'd1, 5'd2, 32'h0, 32'h0);
        #1 check("post_rst_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("post_rst_dest", 64'(bus.alu_pkt.dest), 64'h21);
        bus.in_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dispatch_stage.md
DISPATCH_STAGE -- requirements
Module: dispatch_stage

Interface
REQ-001 Parameter DATA_W, 32, operand/immediate/address width.
REQ-002 Parameter NAME_W, 5, architectural register name width.
REQ-003 Parameter ALU_DEPTH, 16, ALU reservation-station entries (power of two, >=2).
REQ-004 Parameter LS_DEPTH, 16, LS buffer entries (power of two, >=2).
REQ-005 clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-006 flush  in  1  mispredict flush, synchronous.
REQ-007 in_valid in 1 / in_ready out 1  decoder handshake.
REQ-008 in_class in CLS_W, in_op in OP_W, in_addr in DATA_W, in_rd in NAME_W, in_imm in DATA_W  decoded fields (imm pre-selected by decoder).
REQ-009 src1_tag/src2_tag in TAG_W, src1_data/src2_data in DATA_W  regfile lookup.
REQ-010 alu_free in ALU_DEPTH, ls_free in LS_DEPTH  free-entry bitmaps, 1 = free.
REQ-011 ren_en out 1, ren_name out NAME_W, ren_tag out TAG_W  rename write to regfile.
REQ-012 alu_valid out 1, alu_ready in 1, alu_pkt out; br_valid/br_ready/br_pkt; ls_valid/ls_ready/ls_pkt  per-channel valid/ready.

Function
REQ-013 Tag = {valid bit, unit bit (0 ALU, 1 LS), index}; TAG_FREE = 0 means operand is ready.
REQ-014 Class routing: LUI, AUIPC, JAL, JALR, RI, RR -> ALU; B -> BR; LD, ST -> LS; other classes accepted and dropped, no output.
REQ-015 Operand map: RR, B, ST use src1+src2; LUI, AUIPC, JAL, JALR, RI, LD use src1 + in_imm, tag2 = TAG_FREE; B, LD, ST also carry in_imm; ALU and BR carry in_addr.
REQ-016 Allocated index = lowest set bit of (free & ~inflight) for the target unit; ALU and LD/ST allocate, B does not.
REQ-017 Destination tag written to pkt for ALU classes and LD; ST pkt has dest tag = allocated LS tag, no rename.
REQ-018 in_ready = !flush && target channel slot empty-or-draining (valid && ready) && free entry exists (allocating classes).
REQ-019 Transfer on in_valid && in_ready; channel valid and payload registered next edge; latency 1 cycle.
REQ-020 Channel payload SHALL stay stable while valid && !ready.
REQ-021 ren_en pulses 1 cycle, aligned with the channel valid, for ALU classes and LD with in_rd != 0; rd = 0 allocates tag, no rename.
REQ-022 inflight bit set on allocation; cleared when corresponding free input reads 0 (RS has registered occupancy).
REQ-023 Simultaneous allocate and clear of the same bit: set wins.
REQ-024 flush: all channel valids, ren_en, inflight cleared next edge; no acceptance that cycle.
REQ-025 Exactly one channel loaded per accepted instruction; no channel is loaded without a transfer.

Reset
REQ-026 rst clears alu_valid, br_valid, ls_valid, ren_en, inflight to 0; payloads to 0 (op = NOP, tags TAG_FREE).
REQ-027 rst mid-operation discards held payloads; in_ready reflects post-reset state next cycle.

Structure
REQ-028 Shared package dispatch_pkg holds class codes, NOP, CLS_W, OP_W, TAG_W, TAG_FREE, unit-bit constants, packet typedefs.
REQ-029 Sub-module free_tag_picker (masked lowest-set-bit priority encoder, found flag + index) instantiated for ALU and LS.

Verification
REQ-030 RR, rd=3, alu_free=16'h0006, src tags 0 -> next cycle alu_valid=1, dest index 1, ren_en=1, ren_name=3.
REQ-031 Two back-to-back RI with alu_free held 16'h0006 -> indices 1 then 2 (inflight mask), no duplicate tag.
REQ-032 LD with ls_free=0 -> in_ready=0, no ls_valid; raise ls_free=16'h8000 -> accepted, index 15.
REQ-033 B with br_ready=0 held 3 cycles -> br_valid stays 1, payload unchanged, second B stalls.
REQ-034 ST, src2_tag valid -> ls_pkt keeps src2 tag, ren_en=0.
REQ-035 Flush with all channels valid -> all valids 0 next edge, then rst mid-stall -> all outputs at reset values.
